// File: rtl/ysyx_25060173_pipe_buf_if.sv
// Valid/ready bundle between a producer, the pipeline buffer and a consumer.
// The master side drives the producer/consumer controls; the slave side is the buffer.
interface ysyx_25060173_pipe_buf_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
);
   logic                          flush;
   logic                          in_valid;
   logic                          in_ready;
   logic [WIDTH-1:0]              in_data;
   logic                          out_valid;
   logic                          out_ready;
   logic [WIDTH-1:0]              out_data;
   logic [$clog2(DEPTH+1)-1:0]    count;

   modport master (
      output flush, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  flush, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/ysyx_25060173_pipe_buf.sv
// N-deep, W-wide valid/ready pipeline buffer (circular FIFO).
// in_ready/out_valid come from registered occupancy only, so backpressure never
// forms a combinational ready chain across stages.
// Optional same-cycle pass-through when empty: define YSYX_25060173_PIPE_BUF_BYPASS_EN.
module ysyx_25060173_pipe_buf #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic                    clk,
   input logic                    rst,
   ysyx_25060173_pipe_buf_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic store;
   logic take;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   assign bus.in_ready = ~full;
   assign bus.count    = count_q;
   assign push         = bus.in_valid & ~full;
   assign pop          = bus.out_valid & bus.out_ready;

`ifdef YSYX_25060173_PIPE_BUF_BYPASS_EN
   logic pass;

   // An empty buffer presents the incoming beat directly; if the consumer takes it,
   // the beat never touches storage.
   assign pass          = empty & bus.in_valid;
   assign bus.out_valid = ~empty | pass;
   assign bus.out_data  = ~empty ? mem[rd_ptr] : (bus.in_valid ? bus.in_data : RESET_VAL);
   assign store         = push & ~(pass & bus.out_ready);
   assign take          = pop & ~empty;
`else
   assign bus.out_valid = ~empty;
   assign bus.out_data  = empty ? RESET_VAL : mem[rd_ptr];
   assign store         = push;
   assign take          = pop;
`endif

   // Payload storage; deliberately not reset, contents are only meaningful while counted.
   always_ff @(posedge clk) begin
      if (store && !bus.flush) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   // Pointers and occupancy; flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (take) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (store && !take) begin
            count_q <= count_q + CW'(1);
         end else if (take && !store) begin
            count_q <= count_q - CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_ysyx_25060173_pipe_buf.sv
// Bench for the pipeline buffer: a DEPTH=4 and a DEPTH=2 instance receive identical
// stimulus and are each compared every cycle against a queue-based model.
module tb_ysyx_25060173_pipe_buf;
   localparam logic [7:0] RV = 8'hE7;
`ifdef YSYX_25060173_PIPE_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ysyx_25060173_pipe_buf_if #(.WIDTH(8), .DEPTH(4)) b4 ();
   ysyx_25060173_pipe_buf_if #(.WIDTH(8), .DEPTH(2)) b2 ();

   ysyx_25060173_pipe_buf #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) u_buf4 (
      .clk(clk), .rst(rst), .bus(b4)
   );
   ysyx_25060173_pipe_buf #(.WIDTH(8), .DEPTH(2), .RESET_VAL(RV)) u_buf2 (
      .clk(clk), .rst(rst), .bus(b2)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] q4[$];
   logic [7:0] q2[$];

   logic       s_iv, s_ordy, s_fl;
   logic [7:0] s_id;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs and the queue operation implied by the current inputs.
   function automatic void model_eval(input int sz, input int depth, input logic [7:0] head,
                                      output logic ov, output logic [7:0] od, output logic ir,
                                      output logic do_push, output logic do_pop);
      ir = (sz < depth);
      if (sz > 0) begin
         ov = 1'b1;
         od = head;
      end else if (BYP && s_iv) begin
         ov = 1'b1;
         od = s_id;
      end else begin
         ov = 1'b0;
         od = RV;
      end
      do_push = s_iv && ir;
      do_pop  = ov && s_ordy;
      if (sz == 0 && do_pop) begin
         do_push = 1'b0;
         do_pop  = 1'b0;
      end
   endfunction

   task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
      logic ov, ir, dpu, dpo;
      logic [7:0] od;
      @(negedge clk);
      s_iv = iv; s_id = id; s_ordy = ordy; s_fl = fl;
      b4.in_valid = iv; b4.in_data = id; b4.out_ready = ordy; b4.flush = fl;
      b2.in_valid = iv; b2.in_data = id; b2.out_ready = ordy; b2.flush = fl;
      #1;
      model_eval(q4.size(), 4, (q4.size() > 0) ? q4[0] : 8'h00, ov, od, ir, dpu, dpo);
      chk("d4_count", 32'(b4.count), 32'(q4.size()));
      chk("d4_in_ready", 32'(b4.in_ready), 32'(ir));
      chk("d4_out_valid", 32'(b4.out_valid), 32'(ov));
      chk("d4_out_data", 32'(b4.out_data), 32'(od));
      if (fl) q4.delete();
      else begin
         if (dpo) void'(q4.pop_front());
         if (dpu) q4.push_back(id);
      end
      model_eval(q2.size(), 2, (q2.size() > 0) ? q2[0] : 8'h00, ov, od, ir, dpu, dpo);
      chk("d2_count", 32'(b2.count), 32'(q2.size()));
      chk("d2_in_ready", 32'(b2.in_ready), 32'(ir));
      chk("d2_out_valid", 32'(b2.out_valid), 32'(ov));
      chk("d2_out_data", 32'(b2.out_data), 32'(od));
      if (fl) q2.delete();
      else begin
         if (dpo) void'(q2.pop_front());
         if (dpu) q2.push_back(id);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_d4_count"}, 32'(b4.count), 32'd0);
      chk({tag, "_d4_in_ready"}, 32'(b4.in_ready), 32'd1);
      chk({tag, "_d4_out_valid"}, 32'(b4.out_valid), 32'd0);
      chk({tag, "_d4_out_data"}, 32'(b4.out_data), 32'(RV));
      chk({tag, "_d2_count"}, 32'(b2.count), 32'd0);
      chk({tag, "_d2_out_valid"}, 32'(b2.out_valid), 32'd0);
   endtask

   initial begin
      logic [7:0] fill [4];
      fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
      s_iv = 0; s_id = 0; s_ordy = 0; s_fl = 0;
      b4.in_valid = 0; b4.in_data = 0; b4.out_ready = 0; b4.flush = 0;
      b2.in_valid = 0; b2.in_data = 0; b2.out_ready = 0; b2.flush = 0;
      #2;
      chk_reset("por");
      @(negedge clk);
      rst = 1'b1;

      // Fill to full, an ignored extra push, then drain.
      for (int i = 0; i < 4; i++) step(1'b1, fill[i], 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Simultaneous push and pop at count 1.
      step(1'b1, 8'hA0, 1'b0, 1'b0);
      step(1'b1, 8'hB0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Wrap: ten push/pop pairs.
      step(1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) step(1'b1, 8'(i * 7), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush at count 3 with a same-cycle push and pop.
      for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'hDD, 1'b1, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Empty buffer, beat offered and accepted in the same cycle.
      step(1'b1, 8'h5A, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Asynchronous reset with two entries held.
      step(1'b1, 8'h61, 1'b0, 1'b0);
      step(1'b1, 8'h62, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1 chk_reset("mid");
      q4.delete();
      q2.delete();
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 40) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
